// File: rtl/sp_ram_arbiter.sv
// sp_ram_arbiter: two-master arbiter/sequencer with bounded bus-lock in front of sp_ram_wrap
// Ports: clk, rst_i; per master mN_req/lock/addr/we/be/wdata in, mN_gnt/rvalid/rdata out;
//        ram_en/addr/we/be/wdata out to sp_ram_wrap, ram_rdata_i back from it.
// Config: SP_RAM_ARB_ROUND_ROBIN_EN selects round-robin; undefined gives m0 fixed priority.
module sp_ram_arbiter #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_LOCK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_i,
  input  logic                    m0_req_i,
  input  logic                    m0_lock_i,
  input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
  input  logic                    m0_we_i,
  input  logic [DATA_WIDTH/8-1:0] m0_be_i,
  input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
  output logic                    m0_gnt_o,
  output logic                    m0_rvalid_o,
  output logic [DATA_WIDTH-1:0]   m0_rdata_o,
  input  logic                    m1_req_i,
  input  logic                    m1_lock_i,
  input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
  input  logic                    m1_we_i,
  input  logic [DATA_WIDTH/8-1:0] m1_be_i,
  input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
  output logic                    m1_gnt_o,
  output logic                    m1_rvalid_o,
  output logic [DATA_WIDTH-1:0]   m1_rdata_o,
  output logic                    ram_en_o,
  output logic [ADDR_WIDTH-1:0]   ram_addr_o,
  output logic                    ram_we_o,
  output logic [DATA_WIDTH/8-1:0] ram_be_o,
  output logic [DATA_WIDTH-1:0]   ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);
  localparam int CW = MAX_LOCK_CYCLES > 1 ? $clog2(MAX_LOCK_CYCLES) : 1;
  typedef enum logic {ARB, LOCKED} state_t;
  state_t state;
  logic owner, blk, blk_id, rv, rid, rwe;
  logic [CW-1:0] cnt;
  logic locked, pri, g0, g1, gnt, lk, own_req, own_lock, take_lock, forced;
  assign locked = state == LOCKED;
  assign own_req = owner ? m1_req_i : m0_req_i;
  assign own_lock = owner ? m1_lock_i : m0_lock_i;
  // pri names the master that wins a tie in ARB
`ifdef SP_RAM_ARB_ROUND_ROBIN_EN
  logic ptr;
  always_ff @(posedge clk)
    if (rst_i) ptr <= 1'b0;
    else if (forced || (locked ? own_req && !own_lock : gnt && !take_lock)) ptr <= locked ? !owner : !g1;
  assign pri = ptr;
`else
  // one-cycle priority flip after a forced release lets the starved master in
  assign pri = blk && !blk_id;
`endif
  assign g0 = !rst_i && m0_req_i && (locked ? !owner : !(m1_req_i && pri));
  assign g1 = !rst_i && m1_req_i && (locked ? owner : !(m0_req_i && !pri));
  assign gnt = g0 || g1;
  assign lk = g1 ? m1_lock_i : m0_lock_i;
  // a master just forcibly released may not re-lock on the very next cycle
  assign take_lock = !locked && gnt && lk && !(blk && blk_id == g1);
  assign forced = locked && cnt == CW'(MAX_LOCK_CYCLES - 1);
  always_ff @(posedge clk)
    if (rst_i) begin
      state <= ARB;
      owner <= 1'b0;
      cnt <= '0;
      blk <= 1'b0;
      blk_id <= 1'b0;
      rv <= 1'b0;
      rid <= 1'b0;
      rwe <= 1'b0;
    end else begin
      rv <= gnt;
      rid <= g1;
      rwe <= ram_we_o;
      blk <= forced;
      if (forced) blk_id <= owner;
      cnt <= take_lock ? '0 : cnt + CW'(1);
      if (take_lock) begin
        state <= LOCKED;
        owner <= g1;
      end else if (forced || (locked && !own_lock)) state <= ARB;
    end
  assign ram_en_o = gnt;
  assign ram_we_o = g1 ? m1_we_i : g0 && m0_we_i;
  assign ram_addr_o = g1 ? m1_addr_i : g0 ? m0_addr_i : '0;
  assign ram_be_o = g1 ? m1_be_i : g0 ? m0_be_i : '0;
  assign ram_wdata_o = g1 ? m1_wdata_i : g0 ? m0_wdata_i : '0;
  assign m0_gnt_o = g0;
  assign m1_gnt_o = g1;
  // reset drops an in-flight response immediately
  assign m0_rvalid_o = rv && !rid && !rst_i;
  assign m1_rvalid_o = rv && rid && !rst_i;
  assign m0_rdata_o = m0_rvalid_o && !rwe ? ram_rdata_i : '0;
  assign m1_rdata_o = m1_rvalid_o && !rwe ? ram_rdata_i : '0;
endmodule

// File: tb/tb_sp_ram_arbiter.sv
// tb_sp_ram_arbiter: randomized and directed checks of sp_ram_arbiter against a behavioural model
module tb_sp_ram_arbiter;
  localparam int AW = 15, DW = 32, BW = 4, MAXL = 16;
`ifdef SP_RAM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic req[2], lock[2], we[2];
  logic [AW-1:0] addr[2];
  logic [BW-1:0] be[2];
  logic [DW-1:0] wdata[2];
  logic [DW-1:0] ram_rdata = '0;
  logic m0_gnt, m1_gnt, m0_rv, m1_rv, ram_en, ram_we;
  logic [DW-1:0] m0_rd, m1_rd, ram_wdata;
  logic [AW-1:0] ram_addr;
  logic [BW-1:0] ram_be;
  logic [120:0] got, exp_v;
  int checks = 0, errors = 0;
  int own = -1, held = 0, pri = 0, barred = -1, pend = -1;
  bit pend_wr = 1'b0;
  assign got = {m0_gnt, m1_gnt, m0_rv, m1_rv, m0_rd, m1_rd, ram_en, ram_we, ram_addr, ram_be, ram_wdata};
  always #5 clk = ~clk;
  sp_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_LOCK_CYCLES(MAXL)) dut (
    .clk(clk), .rst_i(rst),
    .m0_req_i(req[0]), .m0_lock_i(lock[0]), .m0_addr_i(addr[0]), .m0_we_i(we[0]), .m0_be_i(be[0]),
    .m0_wdata_i(wdata[0]), .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rv), .m0_rdata_o(m0_rd),
    .m1_req_i(req[1]), .m1_lock_i(lock[1]), .m1_addr_i(addr[1]), .m1_we_i(we[1]), .m1_be_i(be[1]),
    .m1_wdata_i(wdata[1]), .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rv), .m1_rdata_o(m1_rd),
    .ram_en_o(ram_en), .ram_addr_o(ram_addr), .ram_we_o(ram_we), .ram_be_o(ram_be),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata));
  // who the rules say gets the RAM this cycle (-1 = nobody)
  function automatic int mgrant();
    if (rst) return -1;
    if (own >= 0) return req[own] ? own : -1;
    if (req[0] && req[1]) return pri;
    if (req[0]) return 0;
    if (req[1]) return 1;
    return -1;
  endfunction
  function automatic logic [120:0] model_out();
    int g = mgrant();
    logic v0 = !rst && pend == 0;
    logic v1 = !rst && pend == 1;
    logic [DW-1:0] r0 = (v0 && !pend_wr) ? ram_rdata : '0;
    logic [DW-1:0] r1 = (v1 && !pend_wr) ? ram_rdata : '0;
    if (g < 0) return {2'b00, v0, v1, r0, r1, 2'b00, {AW{1'b0}}, {BW{1'b0}}, {DW{1'b0}}};
    return {g == 0, g == 1, v0, v1, r0, r1, 1'b1, we[g], addr[g], be[g], wdata[g]};
  endfunction
  task automatic model_clk();
    int g = mgrant();
    int nb = -1;
    if (rst) begin
      own = -1; held = 0; pri = 0; barred = -1; pend = -1; pend_wr = 1'b0;
      return;
    end
    pend = g;
    pend_wr = g >= 0 && we[g];
    if (own < 0) begin
      if (g >= 0) begin
        if (lock[g] && barred != g) begin own = g; held = 0; end
        else if (RR) pri = 1 - g;
      end
    end else begin
      held++;
      if (held == MAXL) begin
        nb = own;
        if (RR) pri = 1 - own;
        own = -1;
      end else if (!lock[own]) begin
        if (RR && req[own]) pri = 1 - own;
        own = -1;
      end
    end
    if (!RR) pri = nb >= 0 ? 1 - nb : 0;
    barred = nb;
  endtask
  task automatic tick();
    @(posedge clk);
    model_clk();
    #1;
    ram_rdata = $urandom;
  endtask
  task automatic idle();
    for (int m = 0; m < 2; m++) begin req[m] = 0; lock[m] = 0; we[m] = 0; addr[m] = '0; be[m] = '0; wdata[m] = '0; end
  endtask
  task automatic do_reset();
    idle(); rst = 1; tick(); rst = 0;
  endtask
  task automatic test_reset();
    rst = 1;
    for (int m = 0; m < 2; m++) begin req[m] = 1; lock[m] = 1; we[m] = 1; be[m] = 4'hf; end
    for (int i = 0; i < 3; i++) begin
      #3;
      checks++;
      if (got !== '0) begin errors++; $display("FAIL reset_outputs got=%h exp=0", got); end
      exp_v = model_out(); checks++;
      if (got !== exp_v) begin errors++; $display("FAIL reset_model got=%h exp=%h", got, exp_v); end
      tick();
    end
    idle(); rst = 0; tick();
  endtask
  task automatic test_single_read();
    do_reset();
    req[0] = 1; addr[0] = 15'h0010; be[0] = 4'hf;
    #3;
    exp_v = model_out(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL single_gnt got=%h exp=%h", got, exp_v); end
    checks++;
    if ({m0_gnt, m1_gnt, ram_en, ram_addr} !== {3'b101, 15'h0010}) begin errors++; $display("FAIL single_gnt_direct got=%b exp=101", {m0_gnt, m1_gnt, ram_en}); end
    tick();
    idle(); ram_rdata = 32'hDEADBEEF;
    #3;
    exp_v = model_out(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL single_resp got=%h exp=%h", got, exp_v); end
    checks++;
    if ({m0_rv, m1_rv, m0_rd} !== {2'b10, 32'hDEADBEEF}) begin errors++; $display("FAIL single_resp_direct got=%b %h exp=10 deadbeef", {m0_rv, m1_rv}, m0_rd); end
    tick();
  endtask
  task automatic test_contention();
    int pg = -1;
    do_reset();
    for (int m = 0; m < 2; m++) begin req[m] = 1; addr[m] = AW'(16 * m + 32); be[m] = 4'hf; end
    for (int i = 0; i < 5; i++) begin
      int eg;
      if (!RR && i == 3) req[0] = 0;
      if (i == 4) idle();
      #3;
      exp_v = model_out(); checks++;
      if (got !== exp_v) begin errors++; $display("FAIL contention_model i=%0d got=%h exp=%h", i, got, exp_v); end
      eg = RR ? i % 2 : (i < 3 ? 0 : 1);
      if (i < 4) begin
        checks++;
        if ({m0_gnt, m1_gnt} !== {eg == 0, eg == 1}) begin errors++; $display("FAIL contention_gnt i=%0d got=%b exp_master=%0d", i, {m0_gnt, m1_gnt}, eg); end
      end
      if (pg >= 0) begin
        checks++;
        if ({m0_rv, m1_rv} !== {pg == 0, pg == 1}) begin errors++; $display("FAIL contention_rvalid i=%0d got=%b exp_master=%0d", i, {m0_rv, m1_rv}, pg); end
      end
      pg = eg;
      tick();
    end
  endtask
  task automatic test_lock();
    logic [3:0] e0 = 4'b1000, e1 = 4'b0111;
    do_reset();
    req[1] = 1; lock[1] = 1; be[1] = 4'h3; addr[1] = 15'h0400;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin req[0] = 1; be[0] = 4'hf; addr[0] = 15'h0100; we[1] = 1; wdata[1] = 32'h1234_5678; end
      if (i == 2) lock[1] = 0;
      if (i == 3) begin req[1] = 0; we[1] = 0; end
      #3;
      exp_v = model_out(); checks++;
      if (got !== exp_v) begin errors++; $display("FAIL lock_model i=%0d got=%h exp=%h", i, got, exp_v); end
      checks++;
      if ({m0_gnt, m1_gnt} !== {e0[i], e1[i]}) begin errors++; $display("FAIL lock_gnt i=%0d got=%b exp=%b", i, {m0_gnt, m1_gnt}, {e0[i], e1[i]}); end
      tick();
    end
    idle(); tick();
  endtask
  task automatic test_forced_release();
    do_reset();
    for (int m = 0; m < 2; m++) begin req[m] = 1; be[m] = 4'hf; addr[m] = AW'(m * 4); end
    lock[0] = 1;
    for (int i = 0; i < 20; i++) begin
      #3;
      exp_v = model_out(); checks++;
      if (got !== exp_v) begin errors++; $display("FAIL forced_model i=%0d got=%h exp=%h", i, got, exp_v); end
      if (i < 18) begin
        checks++;
        if ({m0_gnt, m1_gnt} !== {i <= 16, i == 17}) begin errors++; $display("FAIL forced_gnt i=%0d got=%b exp=%b", i, {m0_gnt, m1_gnt}, {i <= 16, i == 17}); end
      end
      tick();
    end
    idle(); tick(); tick();
  endtask
  task automatic test_reset_mid();
    do_reset();
    req[1] = 1; lock[1] = 1; be[1] = 4'hf;
    #3;
    checks++;
    if (m1_gnt !== 1'b1) begin errors++; $display("FAIL rstmid_gnt got=%b exp=1", m1_gnt); end
    tick();
    rst = 1; req[1] = 0; lock[1] = 0; req[0] = 1; we[0] = 1; be[0] = 4'h5; wdata[0] = 32'hA5A5_0F0F;
    #3;
    checks++;
    if (got !== '0) begin errors++; $display("FAIL rstmid_outputs got=%h exp=0", got); end
    tick();
    rst = 0; req[1] = 1;
    #3;
    exp_v = model_out(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL rstmid_model got=%h exp=%h", got, exp_v); end
    checks++;
    if ({m0_gnt, m1_gnt, m0_rv, m1_rv} !== 4'b1000) begin errors++; $display("FAIL rstmid_after got=%b exp=1000", {m0_gnt, m1_gnt, m0_rv, m1_rv}); end
    tick();
    idle();
    #3;
    checks++;
    if ({m0_rv, m0_rd} !== {1'b1, 32'h0}) begin errors++; $display("FAIL rstmid_wresp got=%b %h exp=1 0", m0_rv, m0_rd); end
    tick(); tick();
  endtask
  task automatic test_random();
    int last_g = -1;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      for (int m = 0; m < 2; m++)
        if (!req[m] || last_g == m) begin
          req[m] = $urandom_range(0, 3) != 0;
          lock[m] = $urandom_range(0, 2) == 0;
          we[m] = 1'($urandom);
          addr[m] = AW'($urandom);
          be[m] = BW'($urandom);
          wdata[m] = $urandom;
        end
      rst = $urandom_range(0, 99) == 0;
      #3;
      exp_v = model_out(); checks++;
      if (got !== exp_v) begin errors++; $display("FAIL random i=%0d got=%h exp=%h", i, got, exp_v); end
      last_g = mgrant();
      tick();
    end
    rst = 0; idle(); tick();
  endtask
  initial begin
    idle();
    tick(); tick();
    test_reset();
    test_single_read();
    test_contention();
    test_lock();
    test_forced_release();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
